// File: rtl/imem_fetch_port_pkg.sv
// Shared definitions for the instruction-memory fetch port: fault bit positions,
// the NOP returned on faults, latency limit and the buffered response record.
package imem_fetch_port_pkg;

    localparam int          FAULT_MISALIGN = 0;
    localparam int          FAULT_RANGE    = 1;
    localparam logic [31:0] RV_NOP         = 32'h0000_0013;
    localparam int          MAX_LATENCY    = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  fault;
    } fetch_rsp_t;

    localparam int RSP_W = $bits(fetch_rsp_t);

    function automatic logic [1:0] fetch_fault(input logic [1:0] pc_lo, input logic range_err);
        logic [1:0] f;
        f                 = 2'b00;
        f[FAULT_MISALIGN] = (pc_lo != 2'b00);
        f[FAULT_RANGE]    = range_err;
        return f;
    endfunction

endpackage

// File: rtl/imem_fetch_port_rsp_fifo.sv
// Show-ahead response FIFO: head entry is visible on rdata whenever count != 0,
// clear drops everything at the next edge.
module ifetch_rsp_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop_s  = pop & (count_r != '0);
    assign do_push_s = push & ~clear & ((count_r != CW'(DEPTH)) | do_pop_s);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; data is qualified by count so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) store_r[wr_ptr_r] <= wdata;
    end

    assign rdata = (count_r != '0) ? store_r[rd_ptr_r] : '0;
    assign count = count_r;

endmodule

// File: rtl/imem_fetch_port.sv
// Synchronous instruction memory behind a valid/ready fetch port with a fixed-latency
// read pipeline, in-order response buffer, fault reporting and a program-load port.
module imem_fetch_port
    import imem_fetch_port_pkg::*;
#(
    parameter int ADDR_BITS  = 5,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 2,
    parameter int WRAP       = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_pc,
    input  logic                 flush,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_pc,
    output logic [31:0]          rsp_instr,
    output logic [1:0]           rsp_fault,
    input  logic                 ld_en,
    input  logic [ADDR_BITS-1:0] ld_addr,
    input  logic [31:0]          ld_data,
    output logic                 busy
);
    localparam int LAT   = (LATENCY < 1) ? 1 : ((LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY);
    localparam int WORDS = 1 << ADDR_BITS;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      mem_r [WORDS];
    logic             rst_done_r;
    logic [OCC_W-1:0] occ_r;
    logic [OCC_W-1:0] fifo_count_s;
    logic             accept_s;
    logic             pop_s;
    logic             push_s;
    fetch_rsp_t       req_rsp_s;
    fetch_rsp_t       push_data_s;
    fetch_rsp_t       head_s;

    assign req_ready = rst_done_r & ~flush & ~ld_en & (occ_r < OCC_W'(FIFO_DEPTH));
    assign accept_s  = req_valid & req_ready;
    assign rsp_valid = (fifo_count_s != '0);
    assign pop_s     = rsp_valid & rsp_ready;
    assign busy      = (occ_r != '0);

    // Program-load port; the array has no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (ld_en) mem_r[ld_addr] <= ld_data;
    end

    // Read happens at accept so in-flight fetches are unaffected by later loads.
    always_comb begin
        req_rsp_s.pc    = req_pc;
        req_rsp_s.fault = fetch_fault(req_pc[1:0], (WRAP == 0) && (req_pc[31:ADDR_BITS+2] != '0));
        req_rsp_s.instr = (req_rsp_s.fault != 2'b00) ? RV_NOP : mem_r[req_pc[ADDR_BITS+1:2]];
    end

    // Releases req_ready on the first edge after reset deasserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_done_r <= 1'b0;
        else        rst_done_r <= 1'b1;
    end

    // Occupancy counts in-flight plus buffered fetches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    occ_r <= '0;
        else if (flush)                occ_r <= '0;
        else if (accept_s && !pop_s)   occ_r <= occ_r + OCC_W'(1);
        else if (!accept_s && pop_s)   occ_r <= occ_r - OCC_W'(1);
        else                           occ_r <= occ_r;
    end

    generate
        if (LAT == 1) begin : g_direct
            assign push_s      = accept_s;
            assign push_data_s = req_rsp_s;
        end else begin : g_pipe
            fetch_rsp_t       stg_r [LAT-1];
            logic [LAT-2:0]   stg_vld_r;

            // Shift accepted fetches toward the buffer; flush kills every stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stg_vld_r <= '0;
                    for (int i = 0; i < LAT - 1; i++) stg_r[i] <= '0;
                end else begin
                    stg_vld_r[0] <= accept_s;
                    stg_r[0]     <= req_rsp_s;
                    for (int i = 1; i < LAT - 1; i++) begin
                        stg_vld_r[i] <= stg_vld_r[i-1] & ~flush;
                        stg_r[i]     <= stg_r[i-1];
                    end
                end
            end

            assign push_s      = stg_vld_r[LAT-2] & ~flush;
            assign push_data_s = stg_r[LAT-2];
        end
    endgenerate

    ifetch_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push_s),
        .wdata (push_data_s),
        .pop   (pop_s),
        .rdata (head_s),
        .count (fifo_count_s)
    );

    assign rsp_pc    = head_s.pc;
    assign rsp_instr = head_s.instr;
    assign rsp_fault = head_s.fault;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Two configurations (LATENCY 1/WRAP 1 and LATENCY 3/WRAP 0) driven by shared stimulus
// and checked against an in-order scoreboard built from the fetch rules.
module tb_imem_fetch_port;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, flush, rsp_ready, ld_en;
    logic [31:0] req_pc, ld_data;
    logic [4:0]  ld_addr;
    logic [1:0]  rrdy, rvld, bsy;
    logic [31:0] rpc [2];
    logic [31:0] rins [2];
    logic [1:0]  rflt [2];

    always #5 clk = ~clk;

    imem_fetch_port #(.ADDR_BITS(5), .LATENCY(1), .FIFO_DEPTH(2), .WRAP(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rrdy[0]), .req_pc(req_pc),
        .flush(flush), .rsp_valid(rvld[0]), .rsp_ready(rsp_ready), .rsp_pc(rpc[0]),
        .rsp_instr(rins[0]), .rsp_fault(rflt[0]), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .busy(bsy[0]));

    imem_fetch_port #(.ADDR_BITS(5), .LATENCY(3), .FIFO_DEPTH(4), .WRAP(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rrdy[1]), .req_pc(req_pc),
        .flush(flush), .rsp_valid(rvld[1]), .rsp_ready(rsp_ready), .rsp_pc(rpc[1]),
        .rsp_instr(rins[1]), .rsp_fault(rflt[1]), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .busy(bsy[1]));

    // Reference model: memory image plus one FIFO of expected responses per instance.
    logic [31:0] mmem [32];
    logic [31:0] q_pc  [2][256];
    logic [31:0] q_ins [2][256];
    logic [1:0]  q_flt [2][256];
    int          q_rdy [2][256];
    int          hd [2];
    int          tl [2];
    int          cyc;
    bit          rdy_en;
    logic [1:0]  seen_rdy;
    int          n_chk, n_pass;

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int dep_of(int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic logic [1:0] exp_fault(int i, logic [31:0] pc);
        logic [1:0] f;
        f[0] = (pc % 4) != 0;
        f[1] = (i == 1) && (pc >= 32'd128);
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_zero_outputs(input string what);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_rsp_valid[%0d]", what, i), rvld[i], 1'b0);
            chk($sformatf("%s_req_ready[%0d]", what, i), rrdy[i], 1'b0);
            chk($sformatf("%s_busy[%0d]", what, i), bsy[i], 1'b0);
            chk($sformatf("%s_rsp_pc[%0d]", what, i), rpc[i], 32'h0);
            chk($sformatf("%s_rsp_instr[%0d]", what, i), rins[i], 32'h0);
            chk($sformatf("%s_rsp_fault[%0d]", what, i), rflt[i], 2'b00);
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        bit acc [2];
        bit pp  [2];
        @(negedge clk);
        seen_rdy = rrdy;
        for (int i = 0; i < 2; i++) begin
            int occ;
            int k;
            bit er;
            bit ev;
            occ = tl[i] - hd[i];
            k   = hd[i] % 256;
            er  = rdy_en && !flush && !ld_en && (occ < dep_of(i));
            ev  = (occ > 0) && (cyc >= q_rdy[i][k]);
            chk($sformatf("req_ready[%0d]@%0d", i, cyc), rrdy[i], er);
            chk($sformatf("rsp_valid[%0d]@%0d", i, cyc), rvld[i], ev);
            chk($sformatf("busy[%0d]@%0d", i, cyc), bsy[i], occ != 0);
            if (ev) begin
                chk($sformatf("rsp_pc[%0d]@%0d", i, cyc), rpc[i], q_pc[i][k]);
                chk($sformatf("rsp_instr[%0d]@%0d", i, cyc), rins[i], q_ins[i][k]);
                chk($sformatf("rsp_fault[%0d]@%0d", i, cyc), rflt[i], q_flt[i][k]);
            end
            acc[i] = req_valid && er;
            pp[i]  = ev && rsp_ready;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (flush) begin
                hd[i] = tl[i];
            end else begin
                if (pp[i]) hd[i]++;
                if (acc[i]) begin
                    int k;
                    k           = tl[i] % 256;
                    q_pc[i][k]  = req_pc;
                    q_flt[i][k] = exp_fault(i, req_pc);
                    q_ins[i][k] = (q_flt[i][k] != 2'b00) ? NOP : mmem[(req_pc / 4) % 32];
                    q_rdy[i][k] = cyc + lat_of(i);
                    tl[i]++;
                end
            end
        end
        if (ld_en) mmem[ld_addr] = ld_data;
        rdy_en = rst_n;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        flush     = 1'b0;
        ld_en     = 1'b0;
        rsp_ready = 1'b1;
        for (int j = 0; j < n; j++) tick();
    endtask

    initial begin
        int cnt;
        n_chk = 0; n_pass = 0; cyc = 0; rdy_en = 1'b0;
        hd = '{0, 0}; tl = '{0, 0};
        rst_n = 1'b0; req_valid = 1'b0; req_pc = 32'h0; flush = 1'b0;
        rsp_ready = 1'b0; ld_en = 1'b0; ld_addr = 5'd0; ld_data = 32'h0;

        // Reset state.
        #1 chk_zero_outputs("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Preload word i = i through the load port.
        for (int w = 0; w < 32; w++) begin
            ld_en = 1'b1; ld_addr = 5'(w); ld_data = 32'(w);
            tick();
        end
        ld_en = 1'b0;

        // Back-to-back fetches of the whole image.
        rsp_ready = 1'b1; req_valid = 1'b1;
        for (int p = 0; p < 32; p++) begin
            req_pc = 32'(p * 4);
            tick();
        end
        idle(5);

        // Wrap, out-of-range and misaligned fetches.
        req_valid = 1'b1;
        req_pc = 32'h80; tick();
        req_pc = 32'h6;  tick();
        req_pc = 32'h83; tick();
        idle(5);

        // Backpressure: only FIFO_DEPTH requests get in.
        rsp_ready = 1'b0; req_valid = 1'b1; cnt = 0;
        for (int p = 0; p < 6; p++) begin
            req_pc = 32'(32'h20 + p * 4);
            tick();
            cnt += int'(seen_rdy[1]);
        end
        chk("backpressure_accepts_lat3", 32'(cnt), 32'd4);
        idle(8);

        // Flush with two fetches in flight, then a fresh fetch.
        rsp_ready = 1'b0; req_valid = 1'b1;
        req_pc = 32'h10; tick();
        req_pc = 32'h14; tick();
        flush = 1'b1; req_pc = 32'h18; tick();
        flush = 1'b0; req_valid = 1'b0; tick();
        rsp_ready = 1'b1; req_valid = 1'b1; req_pc = 32'h1c; tick();
        idle(5);

        // Load while a request is held, then fetch the new word.
        req_valid = 1'b1; req_pc = 32'h14;
        ld_en = 1'b1; ld_addr = 5'd5; ld_data = 32'hDEAD_BEEF;
        tick();
        ld_en = 1'b0;
        tick();
        idle(5);

        // Random traffic with occasional loads, flushes and bad addresses.
        for (int c = 0; c < 300; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            ld_en     = ($urandom_range(0, 11) == 0);
            ld_addr   = 5'($urandom_range(0, 31));
            ld_data   = $urandom;
            req_pc    = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            if ($urandom_range(0, 7) == 0) req_pc = $urandom;
            else if ($urandom_range(0, 9) == 0) req_pc = req_pc + 32'd128;
            tick();
        end
        idle(6);

        // Asynchronous reset with full buffers mid-transfer.
        rsp_ready = 1'b0; req_valid = 1'b1;
        for (int p = 0; p < 5; p++) begin
            req_pc = 32'(p * 8);
            tick();
        end
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("async_reset");
        hd = tl;
        rdy_en = 1'b0;
        req_valid = 1'b0; rsp_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        req_valid = 1'b1; req_pc = 32'h14; tick();
        req_pc = 32'h7c; tick();
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
